// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Multi-cycle multiplier sequencer for the shared TECS-style ALU. It computes
//   a*b mod 2^WordSize with MSB-first shift-and-add. Doubling is done as acc+acc
//   and accumulation as acc+a, both through the external ALU.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for a request; ALU lines held at the neutral code
//   DOUBLE | acc <= acc + acc for bit cnt of the multiplier
//   ADD    | acc <= acc + a_reg because multiplier bit cnt is set
//   DONE   | product on result; waits for out_ready
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake carrying a (multiplicand), b (multiplier)
//   out_valid/out_ready result handshake carrying result, result_zr, result_ng
//   alu_x, alu_y        ALU operands driven by this block
//   alu_zx..alu_no      ALU control bits driven by this block
//   alu_out             ALU combinational result
`ifndef DefaultWordSize
`define DefaultWordSize 16
`endif

module alu_mul_seq #(
    parameter int WordSize = `DefaultWordSize,
    parameter int CntWidth = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WordSize-1:0] a,
    input  logic [WordSize-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WordSize-1:0] result,
    output logic                result_zr,
    output logic                result_ng,
    output logic [WordSize-1:0] alu_x,
    output logic [WordSize-1:0] alu_y,
    output logic                alu_zx,
    output logic                alu_nx,
    output logic                alu_zy,
    output logic                alu_ny,
    output logic                alu_f,
    output logic                alu_no,
    input  logic [WordSize-1:0] alu_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DOUBLE = 2'd1,
        S_ADD    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    logic [WordSize-1:0]   r_acc;
    logic [WordSize-1:0]   r_a;
    logic [WordSize-1:0]   r_b;
    logic [CntWidth-1:0]   r_cnt;

    state_t                w_state_nxt;
    logic [WordSize-1:0]   w_acc_nxt;
    logic [WordSize-1:0]   w_a_nxt;
    logic [WordSize-1:0]   w_b_nxt;
    logic [CntWidth-1:0]   w_cnt_nxt;
    logic                  w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = CntWidth'(WordSize - 1);
                    w_state_nxt = S_DOUBLE;
                end
            end
            S_DOUBLE: begin
                w_acc_nxt = alu_out;
                // A set bit keeps cnt so ADD can finish the same bit position.
                if (r_b[r_cnt]) begin
                    w_state_nxt = S_ADD;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ADD: begin
                w_acc_nxt = alu_out;
                if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_state_nxt = S_DOUBLE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Everything below depends on registered state only.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        result    = r_acc;
        result_zr = ~|r_acc;
        result_ng = r_acc[WordSize-1];
        alu_x     = '0;
        alu_y     = '0;
        alu_zx    = 1'b0;
        alu_nx    = 1'b0;
        alu_zy    = 1'b0;
        alu_ny    = 1'b0;
        alu_f     = 1'b0;
        alu_no    = 1'b0;
        case (r_state)
            S_DOUBLE: begin
                alu_x = r_acc;
                alu_y = r_acc;
                alu_f = 1'b1;
            end
            S_ADD: begin
                alu_x = r_acc;
                alu_y = r_a;
                alu_f = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        result_zr;
    logic        result_ng;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mul_seq #(.WordSize(16), .CntWidth(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_zr(result_zr), .result_ng(result_ng),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference TECS ALU feeding the sequencer.
    logic [15:0] m_x, m_y, m_f;
    always_comb begin
        m_x = alu_zx ? 16'h0 : alu_x;
        m_x = alu_nx ? ~m_x : m_x;
        m_y = alu_zy ? 16'h0 : alu_y;
        m_y = alu_ny ? ~m_y : m_y;
        m_f = alu_f ? (m_x + m_y) : (m_x & m_y);
        alu_out = alu_no ? ~m_f : m_f;
    end

    function automatic logic [5:0] ctrl();
        return {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_neutral(input string tag);
        chk({tag, "_ctrl_neutral"}, {26'd0, ctrl()}, 32'h00);
        chk({tag, "_xy_neutral"}, {alu_x, alu_y}, 32'h0);
    endtask

    // Full transaction; glitch_at>0 pulses in_valid with junk operands in that busy cycle.
    task automatic do_op(input string tag, input logic [15:0] a_i, input logic [15:0] b_i,
                         input int exp_lat, input logic [15:0] exp_res,
                         input logic exp_zr, input logic exp_ng,
                         input int hold, input int glitch_at);
        int lat;
        int w;
        logic bad_busy;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        chk_neutral({tag, "_idle"});
        a = a_i; b = b_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        chk({tag, "_ready_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        bad_busy = 1'b0;
        while (!out_valid && lat < 100) begin
            if (ctrl() !== 6'b000010 || in_ready !== 1'b0) bad_busy = 1'b1;
            if (glitch_at > 0 && lat == glitch_at) begin
                in_valid = 1'b1; a = 16'h7777; b = 16'hFFFF;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end
        chk({tag, "_busy_ctrl_add"}, {31'd0, bad_busy}, 32'd0);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
        chk({tag, "_zr"}, {31'd0, result_zr}, {31'd0, exp_zr});
        chk({tag, "_ng"}, {31'd0, result_ng}, {31'd0, exp_ng});
        chk_neutral({tag, "_done"});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_result"}, {16'd0, result}, {16'd0, exp_res});
            chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'h0);
        chk("rst_zr_ng", {30'd0, result_zr, result_ng}, 32'b10);
        chk_neutral("rst");

        // 3*5 = 15, latency 16+2
        do_op("t1_3x5", 16'd3, 16'd5, 18, 16'd15, 1'b0, 1'b0, 0, 0);
        // b=0: 16 doublings only
        do_op("t2_bzero", 16'h1234, 16'h0000, 16, 16'h0000, 1'b1, 1'b0, 0, 0);
        // 0xFFFF^2 mod 2^16 = 1, latency 32
        do_op("t3_ffff", 16'hFFFF, 16'hFFFF, 32, 16'h0001, 1'b0, 1'b0, 0, 0);
        // 0x100*0x100 wraps to 0
        do_op("t3_wrap", 16'h0100, 16'h0100, 17, 16'h0000, 1'b1, 1'b0, 0, 0);
        // 0x4000*2 = 0x8000, held for 5 clocks in DONE
        do_op("t4_neg_hold", 16'h4000, 16'h0002, 17, 16'h8000, 1'b0, 1'b1, 5, 0);
        // in_valid pulsed mid-operation is ignored: 0x0123*0x0011 = 0x1353
        do_op("t5_ignore", 16'h0123, 16'h0011, 18, 16'h1353, 1'b0, 1'b0, 0, 4);

        // Reset mid-op when cnt=7: b=0 so each busy edge decrements cnt once.
        a = 16'd5; b = 16'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_still_busy", {30'd0, in_ready, out_valid}, 32'b00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_rst_acc", {16'd0, result}, 32'h0);
        chk_neutral("t6_rst");
        begin
            logic saw_valid;
            saw_valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) saw_valid = 1'b1;
            end
            chk("t6_no_out_valid", {31'd0, saw_valid}, 32'd0);
        end
        do_op("t6_7x6", 16'd7, 16'd6, 18, 16'd42, 1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
